// File: rtl/io_arbiter.sv
// MIX I/O arbiter: CPU command dispatch to NUNITS units plus a 3-cycle memory read/deliver path.
// Define IO_ROUNDROBIN_EN for round-robin unit selection; default build uses fixed priority (unit 0 highest).
module io_arbiter #(
   parameter int NUNITS = 4,
   parameter int AW     = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 io_start,
   input  logic [1:0]           io_unit,
   input  logic [AW-1:0]        io_addr,
   output logic                 io_done,
   input  logic                 cpu_hold,
   output logic [NUNITS-1:0]    unit_start,
   output logic [AW-1:0]        unit_addr,
   input  logic [NUNITS-1:0]    unit_stop,
   input  logic [NUNITS-1:0]    unit_busy,
   input  logic [NUNITS-1:0]    unit_req,
   input  logic [NUNITS*AW-1:0] unit_raddr,
   output logic [NUNITS-1:0]    unit_load,
   output logic [29:0]          word_out,
   output logic                 mem_rd,
   output logic [AW-1:0]        mem_addr,
   input  logic [29:0]          mem_data,
   output logic [NUNITS-1:0]    busy_status
);

   localparam int UW = $clog2(NUNITS);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DELIVER} state_t;

   logic [NUNITS-1:0][AW-1:0] raddr_v;
   assign raddr_v = unit_raddr;

   // ---------------- dispatch ----------------
   logic              pend_q, pend_d;
   logic [UW-1:0]     punit_q, punit_d;
   logic [AW-1:0]     uaddr_q, uaddr_d;
   logic [NUNITS-1:0] ustart_q, ustart_d;
   logic              done_q, done_d;

   always_comb begin
      pend_d   = pend_q;
      punit_d  = punit_q;
      uaddr_d  = uaddr_q;
      ustart_d = '0;
      done_d   = 1'b0;
      // A new command is only accepted once the previous one has been released.
      if (pend_q) begin
         if (unit_stop[punit_q]) begin
            done_d = 1'b1;
            pend_d = 1'b0;
         end
      end else if (io_start) begin
         pend_d            = 1'b1;
         punit_d           = io_unit;
         uaddr_d           = io_addr;
         ustart_d[io_unit] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q   <= 1'b0;
         punit_q  <= '0;
         uaddr_q  <= '0;
         ustart_q <= '0;
         done_q   <= 1'b0;
      end else begin
         pend_q   <= pend_d;
         punit_q  <= punit_d;
         uaddr_q  <= uaddr_d;
         ustart_q <= ustart_d;
         done_q   <= done_d;
      end
   end

   assign unit_start = ustart_q;
   assign unit_addr  = uaddr_q;
   assign io_done    = done_q;

   // ---------------- unit selection ----------------
   logic [UW-1:0] sel;

`ifdef IO_ROUNDROBIN_EN
   logic [UW-1:0] ptr_q, ptr_d;
   logic          found;
   logic [UW-1:0] idx;

   always_comb begin
      sel   = ptr_q;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUNITS; i++) begin
         idx = ptr_q + UW'(i);
         if (!found && unit_req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end
`else
   always_comb begin
      sel = '0;
      for (int i = NUNITS-1; i >= 0; i--) begin
         if (unit_req[i]) sel = UW'(i);
      end
   end
`endif

   // ---------------- memory FSM ----------------
   state_t        state_q, state_d;
   logic [UW-1:0] gnt_q, gnt_d;
   logic [AW-1:0] maddr_q, maddr_d;
   logic [29:0]   word_q, word_d;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      maddr_d = maddr_q;
      word_d  = word_q;
      case (state_q)
         S_IDLE: begin
            if (!cpu_hold && |unit_req) begin
               state_d = S_READ;
               gnt_d   = sel;
               maddr_d = raddr_v[sel];
            end
         end
         S_READ:    state_d = S_DELIVER;
         S_DELIVER: begin
            state_d = S_IDLE;
            word_d  = mem_data;
         end
         default:   state_d = S_IDLE;
      endcase
   end

`ifdef IO_ROUNDROBIN_EN
   always_comb begin
      ptr_d = ptr_q;
      if (state_q == S_IDLE && state_d == S_READ) ptr_d = gnt_d + UW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end
`endif

   logic [NUNITS-1:0] busy_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         maddr_q <= '0;
         word_q  <= '0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         maddr_q <= maddr_d;
         word_q  <= word_d;
         busy_q  <= unit_busy;
      end
   end

   // Load strobe and word are decoded from state so reset kills an in-flight delivery at once.
   assign mem_rd      = (state_q == S_READ);
   assign mem_addr    = maddr_q;
   assign unit_load   = (state_q == S_DELIVER) ? (NUNITS'(1) << gnt_q) : '0;
   assign word_out    = (state_q == S_DELIVER) ? mem_data : word_q;
   assign busy_status = busy_q;

endmodule

// File: tb/tb_io_arbiter.sv
// Randomized + directed bench for io_arbiter against a cycle-timeline reference model.
module tb_io_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        io_start;
   logic [1:0]  io_unit;
   logic [11:0] io_addr;
   logic        io_done;
   logic        cpu_hold;
   logic [3:0]  unit_start;
   logic [11:0] unit_addr;
   logic [3:0]  unit_stop, unit_busy, unit_req, unit_load, busy_status;
   logic [47:0] unit_raddr;
   logic [29:0] word_out, mem_data;
   logic        mem_rd;
   logic [11:0] mem_addr;

   io_arbiter #(.NUNITS(4), .AW(12)) dut (
      .clk(clk), .reset(reset), .io_start(io_start), .io_unit(io_unit), .io_addr(io_addr),
      .io_done(io_done), .cpu_hold(cpu_hold), .unit_start(unit_start), .unit_addr(unit_addr),
      .unit_stop(unit_stop), .unit_busy(unit_busy), .unit_req(unit_req), .unit_raddr(unit_raddr),
      .unit_load(unit_load), .word_out(word_out), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_data(mem_data), .busy_status(busy_status)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: a transaction timeline. A grant at cycle g reads at g+1,
   // delivers at g+2, and the next grant can be decided no earlier than g+3.
   int          cyc_n;
   int          g_cyc, g_unit, m_ptr, m_pu;
   logic        m_pend, m_done;
   logic [3:0]  m_start, m_busy;
   logic [11:0] m_uaddr, m_maddr;
   logic [29:0] m_held;

   task automatic model_reset();
      g_cyc = -100; g_unit = 0; m_ptr = 0; m_pu = 0;
      m_pend = 0; m_done = 0; m_start = 0; m_busy = 0;
      m_uaddr = 0; m_maddr = 0; m_held = 0;
   endtask

   task automatic cyc();
      logic       dlv;
      logic [3:0] exp_ld;
      int         u;
      #1;
      dlv    = (cyc_n == g_cyc + 2);
      exp_ld = dlv ? 4'(1 << g_unit) : 4'b0;
      chk("unit_start", unit_start, m_start);
      chk("unit_addr", unit_addr, m_uaddr);
      chk("io_done", io_done, m_done);
      chk("mem_rd", mem_rd, cyc_n == g_cyc + 1);
      chk("mem_addr", mem_addr, m_maddr);
      chk("unit_load", unit_load, exp_ld);
      chk("word_out", word_out, dlv ? mem_data : m_held);
      chk("busy_status", busy_status, m_busy);
      @(posedge clk);
      m_busy  = unit_busy;
      m_start = 0;
      m_done  = 0;
      if (m_pend) begin
         if (unit_stop[m_pu]) begin m_done = 1; m_pend = 0; end
      end else if (io_start) begin
         m_pend = 1; m_pu = int'(io_unit); m_uaddr = io_addr; m_start = 4'(1 << io_unit);
      end
      if (dlv) m_held = mem_data;
      if (!cpu_hold && unit_req != 0 && cyc_n >= g_cyc + 3) begin
         for (int i = 3; i >= 0; i--) begin
            u = (m_ptr + i) % 4;
            if (unit_req[u]) g_unit = u;
         end
         g_cyc   = cyc_n;
         m_maddr = unit_raddr[g_unit*12 +: 12];
`ifdef IO_ROUNDROBIN_EN
         m_ptr = (g_unit + 1) % 4;
`endif
      end
      cyc_n++;
      @(negedge clk);
   endtask

   // Entered and left at a falling edge.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_io_done", io_done, 0);
      chk("rst_unit_start", unit_start, 0);
      chk("rst_unit_load", unit_load, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_unit_addr", unit_addr, 0);
      chk("rst_word_out", word_out, 0);
      chk("rst_busy_status", busy_status, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic idle_inputs();
      io_start = 0; io_unit = 0; io_addr = 0; cpu_hold = 0;
      unit_stop = 0; unit_busy = 0; unit_req = 0; unit_raddr = 0; mem_data = 0;
   endtask

   int exp_u[5];
   int seen, last;

   initial begin
`ifdef IO_ROUNDROBIN_EN
      exp_u = '{0, 1, 2, 3, 0};
`else
      exp_u = '{0, 0, 0, 0, 0};
`endif
      cyc_n = 0;
      reset = 1'b1;
      idle_inputs();
      model_reset();
      @(negedge clk);
      do_reset();
      cyc();

      // Dispatch, ignored second dispatch, stop from a non-pending unit.
      io_start = 1; io_unit = 2; io_addr = 12'd100;
      cyc();
      io_start = 0;
      chk("r20_start", unit_start, 4'b0100);
      chk("r20_addr", unit_addr, 12'd100);
      io_start = 1; io_unit = 1; io_addr = 12'd200;
      cyc();
      io_start = 0;
      chk("r21_start", unit_start, 4'b0000);
      chk("r21_addr", unit_addr, 12'd100);
      unit_stop = 4'b0010;
      cyc();
      unit_stop = 0;
      chk("r21_done", io_done, 0);
      unit_stop = 4'b0100;
      cyc();
      unit_stop = 0;
      chk("r20_done", io_done, 1);
      cyc();
      chk("r20_done_clr", io_done, 0);

      // Single read; request drops during READ and the transfer still completes.
      unit_req = 4'b0010; unit_raddr = 48'(12'd300) << 12;
      cyc();
      chk("r22_rd", mem_rd, 1);
      chk("r22_addr", mem_addr, 12'd300);
      unit_req = 0;
      cyc();
      mem_data = 30'h12345678;
      #1;
      chk("r22_load", unit_load, 4'b0010);
      chk("r22_word", word_out, 30'h12345678);
      cyc();
      mem_data = 30'h0;
      #1;
      chk("r22_hold", word_out, 30'h12345678);
      cyc();

      // All units requesting continuously.
      do_reset();
      unit_req = 4'b1111;
      unit_raddr = {12'd40, 12'd30, 12'd20, 12'd10};
      seen = 0; last = -1;
      for (int i = 0; i < 16; i++) begin
         mem_data = 30'($urandom);
         cyc();
         if (unit_load != 0 && seen < 5) begin
            chk("r23_unit", unit_load, 4'(1 << exp_u[seen]));
            if (last >= 0) chk("r23_gap", cyc_n - last, 3);
            last = cyc_n;
            seen++;
         end
      end
      chk("r23_count", seen, 5);
      unit_req = 0;
      for (int i = 0; i < 3; i++) cyc();

      // CPU hold blocks new grants.
      unit_req = 4'b1000; unit_raddr = 48'(12'h7AB) << 36; cpu_hold = 1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("r24_hold", mem_rd, 0);
      end
      cpu_hold = 0;
      cyc();
      chk("r24_rd", mem_rd, 1);
      chk("r24_addr", mem_addr, 12'h7AB);
      unit_req = 0;
      for (int i = 0; i < 3; i++) cyc();

      // Reset in the middle of a READ.
      unit_req = 4'b0001; unit_raddr = 48'(12'd55);
      cyc();
      chk("r25_rd", mem_rd, 1);
      do_reset();
      cyc();
      cyc();
      mem_data = 30'h2AAA5555;
      #1;
      chk("r25_load", unit_load, 4'b0001);
      chk("r25_word", word_out, 30'h2AAA5555);
      cyc();
      unit_req = 0;
      cyc();

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         io_start   = ($urandom % 4 == 0);
         io_unit    = 2'($urandom);
         io_addr    = 12'($urandom);
         cpu_hold   = ($urandom % 4 == 0);
         unit_stop  = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0;
         unit_busy  = 4'($urandom);
         unit_req   = ($urandom % 3 == 0) ? 4'b0 : 4'($urandom);
         unit_raddr = {16'($urandom), 32'($urandom)};
         mem_data   = 30'($urandom);
         if ($urandom % 300 == 0) do_reset();
         else cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
